mealy_seq_sched: RTL and testbench

//  Round-robin scheduler that shares one mealy sequence detector between NREQ requesters.

---
 rtl/mealy_seq_sched.sv | 231 +++++++++++++++++++++++
 tb/tb_mealy_seq_sched.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mealy_seq_sched.sv
// -----------------------------------------------------------------------------
// mealy_seq_sched
//   Round-robin scheduler that time-shares one mealy sequence detector between
//   NREQ requesters. The winner's packed SEQ_LEN-symbol sequence is latched at
//   grant time and streamed into the detector one symbol per clock. The
//   detector's done/detect verdict, or a timeout, is returned to that requester
//   as a one-cycle response. FLUSH_CYC idle symbols then clear any partial match
//   before the next grant.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   req         per-requester request level
//   req_seq     requester r at [r*SEQ_LEN*SYM_W +: SEQ_LEN*SYM_W], symbol 0 in LSBs
//   gnt         one-hot grant (registered)
//   det_inp     symbol driven to the detector (registered)
//   det_done    detector done
//   det_detect  detector detect code
//   resp_valid  one-cycle response strobe
//   resp_id     index of the responding requester
//   resp_match  1 = done seen inside the window, 0 = timeout
//   resp_code   det_detect captured with done, 0 on timeout
//   busy        high in every state except IDLE
// -----------------------------------------------------------------------------
module mealy_seq_sched #(
    parameter int NREQ      = 4,
    parameter int SYM_W     = 3,
    parameter int SEQ_LEN   = 4,
    parameter int TIMEOUT   = 8,
    parameter int FLUSH_CYC = 2,
    parameter int IDLE_SYM  = 7
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NREQ-1:0]                 req,
    input  logic [NREQ*SEQ_LEN*SYM_W-1:0]   req_seq,
    output logic [NREQ-1:0]                 gnt,
    output logic [SYM_W-1:0]                det_inp,
    input  logic                            det_done,
    input  logic [1:0]                      det_detect,
    output logic                            resp_valid,
    output logic [$clog2(NREQ)-1:0]         resp_id,
    output logic                            resp_match,
    output logic [1:0]                      resp_code,
    output logic                            busy
);

    localparam int PTR_W    = $clog2(NREQ);
    localparam int SEQ_BITS = SEQ_LEN * SYM_W;
    localparam int IDX_W    = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam int TMR_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int FL_W     = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    localparam logic [SYM_W-1:0] IDLE_S    = SYM_W'(IDLE_SYM);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(SEQ_LEN - 1);
    localparam logic [TMR_W-1:0] LAST_TMR  = TMR_W'(TIMEOUT - 1);
    localparam logic [FL_W-1:0]  LAST_FL   = FL_W'(FLUSH_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FEED  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_FLUSH = 3'd4
    } state_t;

    state_t               state_r;
    logic [PTR_W-1:0]     ptr_r;
    logic [IDX_W-1:0]     feed_idx_r;
    logic [TMR_W-1:0]     timer_r;
    logic [FL_W-1:0]      flush_r;
    // Remaining symbols of the latched sequence; next symbol always in the LSBs.
    logic [SEQ_BITS-1:0]  seq_r;

    logic                 win_found_s;
    logic [PTR_W-1:0]     win_idx_s;
    logic [PTR_W-1:0]     cand_s;
    logic [NREQ-1:0]      win_onehot_s;
    logic [SEQ_BITS-1:0]  win_seq_s;

    // Round-robin search: first requesting index strictly after ptr_r, wrapping,
    // so the last winner is considered last.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        cand_s      = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand_s = PTR_W'((int'(ptr_r) + i) % NREQ);
            if (!win_found_s && req[cand_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s;
            end else begin
                win_idx_s   = win_idx_s;
            end
        end
    end

    // Decode the winner into a one-hot grant and select its packed sequence.
    always_comb begin
        win_onehot_s = '0;
        win_seq_s    = '0;
        for (int r = 0; r < NREQ; r++) begin
            if (win_idx_s == PTR_W'(r)) begin
                win_onehot_s[r] = 1'b1;
                win_seq_s       = req_seq[r*SEQ_BITS +: SEQ_BITS];
            end else begin
                win_onehot_s[r] = 1'b0;
            end
        end
    end

    // Scheduler FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            ptr_r      <= PTR_W'(NREQ - 1);
            feed_idx_r <= '0;
            timer_r    <= '0;
            flush_r    <= '0;
            seq_r      <= '0;
            gnt        <= '0;
            det_inp    <= IDLE_S;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_match <= 1'b0;
            resp_code  <= 2'd0;
            busy       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    det_inp <= IDLE_S;
                    if (win_found_s) begin
                        gnt        <= win_onehot_s;
                        det_inp    <= win_seq_s[SYM_W-1:0];
                        seq_r      <= win_seq_s >> SYM_W;
                        ptr_r      <= win_idx_s;
                        feed_idx_r <= '0;
                        busy       <= 1'b1;
                        state_r    <= ST_FEED;
                    end else begin
                        gnt        <= '0;
                        busy       <= 1'b0;
                    end
                end

                ST_FEED: begin
                    if (feed_idx_r == LAST_IDX) begin
                        // Last symbol is on det_inp: this is the first cycle of
                        // the done window.
                        det_inp <= IDLE_S;
                        timer_r <= '0;
                        if (det_done) begin
                            resp_valid <= 1'b1;
                            resp_id    <= ptr_r;
                            resp_match <= 1'b1;
                            resp_code  <= det_detect;
                            state_r    <= ST_RESP;
                        end else if (TIMEOUT == 0) begin
                            resp_valid <= 1'b1;
                            resp_id    <= ptr_r;
                            resp_match <= 1'b0;
                            resp_code  <= 2'd0;
                            state_r    <= ST_RESP;
                        end else begin
                            state_r    <= ST_WAIT;
                        end
                    end else begin
                        det_inp    <= seq_r[SYM_W-1:0];
                        seq_r      <= seq_r >> SYM_W;
                        feed_idx_r <= feed_idx_r + IDX_W'(1);
                    end
                end

                ST_WAIT: begin
                    det_inp <= IDLE_S;
                    // Done is tested before expiry so a done on the final
                    // window cycle still counts as a match.
                    if (det_done) begin
                        resp_valid <= 1'b1;
                        resp_id    <= ptr_r;
                        resp_match <= 1'b1;
                        resp_code  <= det_detect;
                        state_r    <= ST_RESP;
                    end else if (timer_r == LAST_TMR) begin
                        resp_valid <= 1'b1;
                        resp_id    <= ptr_r;
                        resp_match <= 1'b0;
                        resp_code  <= 2'd0;
                        state_r    <= ST_RESP;
                    end else begin
                        timer_r    <= timer_r + TMR_W'(1);
                    end
                end

                ST_RESP: begin
                    det_inp    <= IDLE_S;
                    resp_valid <= 1'b0;
                    resp_id    <= '0;
                    resp_match <= 1'b0;
                    resp_code  <= 2'd0;
                    gnt        <= '0;
                    flush_r    <= '0;
                    state_r    <= ST_FLUSH;
                end

                ST_FLUSH: begin
                    det_inp <= IDLE_S;
                    gnt     <= '0;
                    if (flush_r == LAST_FL) begin
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        flush_r <= flush_r + FL_W'(1);
                    end
                end

                default: begin
                    state_r    <= ST_IDLE;
                    gnt        <= '0;
                    det_inp    <= IDLE_S;
                    resp_valid <= 1'b0;
                    resp_id    <= '0;
                    resp_match <= 1'b0;
                    resp_code  <= 2'd0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mealy_seq_sched.sv
// -----------------------------------------------------------------------------
// tb_mealy_seq_sched
//   Directed bench for mealy_seq_sched. A behavioural mealy detector (0,6,4,2 ->
//   done, detect=3) answers the DUT; an optional forced done pulse (detect=1)
//   is injected at a chosen cycle of a grant. Expected responses are queued when
//   stimulus is issued and a negedge monitor pops and compares them.
// -----------------------------------------------------------------------------
module tb_mealy_seq_sched;

    localparam int NREQ    = 4;
    localparam int SYM_W   = 3;
    localparam int SEQ_LEN = 4;
    localparam int SB      = SEQ_LEN * SYM_W;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [NREQ-1:0]           req;
    logic [NREQ*SB-1:0]        req_seq;
    logic [NREQ-1:0]           gnt;
    logic [SYM_W-1:0]          det_inp;
    logic                      det_done;
    logic [1:0]                det_detect;
    logic                      resp_valid;
    logic [1:0]                resp_id;
    logic                      resp_match;
    logic [1:0]                resp_code;
    logic                      busy;

    typedef struct packed {
        logic [1:0] id;
        logic       match;
        logic [1:0] code;
    } resp_t;

    resp_t sb[$];
    resp_t mon_e;

    int checks = 0;
    int errors = 0;

    // detector model / force control
    logic [1:0] st;
    logic       model_done;
    logic       frc;
    logic       force_en;
    int         force_age;
    int         age = 0;

    mealy_seq_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_seq    (req_seq),
        .gnt        (gnt),
        .det_inp    (det_inp),
        .det_done   (det_done),
        .det_detect (det_detect),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_match (resp_match),
        .resp_code  (resp_code),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Mealy detector for 0,6,4,2; any mismatch restarts (0 restarts at stage 1).
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= 2'd0;
        end else begin
            case (st)
                2'd0: st <= (det_inp == 3'd0) ? 2'd1 : 2'd0;
                2'd1: st <= (det_inp == 3'd6) ? 2'd2 : ((det_inp == 3'd0) ? 2'd1 : 2'd0);
                2'd2: st <= (det_inp == 3'd4) ? 2'd3 : ((det_inp == 3'd0) ? 2'd1 : 2'd0);
                default: st <= (det_inp == 3'd0) ? 2'd1 : 2'd0;
            endcase
        end
    end

    // Cycles since the grant rose: 0 on the first granted cycle.
    always @(posedge clk) age <= (gnt != 4'b0000) ? age + 1 : 0;

    always_comb begin
        model_done = (st == 2'd3) && (det_inp == 3'd2);
        frc        = force_en && (gnt != 4'b0000) && (age == force_age);
        det_done   = model_done || frc;
        det_detect = frc ? 2'd1 : (model_done ? 2'd3 : 2'd0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [SB-1:0] pack(input logic [2:0] a, input logic [2:0] b,
                                           input logic [2:0] c, input logic [2:0] d);
        return {d, c, b, a};
    endfunction

    task automatic push(input int id, input logic m, input logic [1:0] c);
        resp_t e;
        e.id    = 2'(id);
        e.match = m;
        e.code  = c;
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 60) begin
            tick();
            n++;
        end
        check("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    // One request from requester id; req is dropped once granted. rc is the
    // cycle (relative to T, the cycle req is first seen) of the response.
    task automatic run_req(input int id, input logic [SB-1:0] seqv, input int fage,
                           input logic fen, input logic em, input logic [1:0] ec,
                           input int rc);
        logic [NREQ-1:0] exp_g;
        exp_g     = '0;
        exp_g[id] = 1'b1;
        req_seq   = '0;
        req_seq[id*SB +: SB] = seqv;
        req       = exp_g;
        force_en  = fen;
        force_age = fage;
        push(id, em, ec);
        for (int k = 1; k <= rc + 3; k++) begin
            tick();
            if (k == 1) begin
                check("gnt", {28'd0, gnt}, {28'd0, exp_g});
                req = '0;
            end
            if (k <= SEQ_LEN) check("det_inp_sym", {29'd0, det_inp}, {29'd0, seqv[(k-1)*SYM_W +: SYM_W]});
            if (k == rc - 1) check("resp_early", {31'd0, resp_valid}, 32'd0);
            if (k == rc)     check("resp_latency", {31'd0, resp_valid}, 32'd1);
            if (k == rc + 2) check("busy_flush", {31'd0, busy}, 32'd1);
            if (k == rc + 3) check("busy_idle", {31'd0, busy}, 32'd0);
        end
        force_en = 1'b0;
    endtask

    // Monitor: grant one-hot check every cycle, scoreboard pop on each response.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("gnt_onehot", {31'd0, ($countones(gnt) > 1)}, 32'd0);
            if (resp_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL resp_unexpected: got id %0d expected no response", resp_id);
                end else begin
                    mon_e = sb.pop_front();
                    check("resp_id",    {30'd0, resp_id},    {30'd0, mon_e.id});
                    check("resp_match", {31'd0, resp_match}, {31'd0, mon_e.match});
                    check("resp_code",  {30'd0, resp_code},  {30'd0, mon_e.code});
                end
            end
        end
    end

    initial begin
        logic [NREQ-1:0] prev;
        logic [NREQ-1:0] exp_order [5];
        int zeros;
        int ngr;

        rst_n     = 1'b0;
        req       = '0;
        req_seq   = '0;
        force_en  = 1'b0;
        force_age = 0;
        repeat (3) tick();
        check("rst_gnt",   {28'd0, gnt},        32'd0);
        check("rst_inp",   {29'd0, det_inp},    32'd7);
        check("rst_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_busy",  {31'd0, busy},       32'd0);
        check("rst_id",    {30'd0, resp_id},    32'd0);
        check("rst_match", {31'd0, resp_match}, 32'd0);
        check("rst_code",  {30'd0, resp_code},  32'd0);
        rst_n = 1'b1;
        tick();

        // matching sequence: done on the last FEED cycle
        run_req(0, pack(3'd0, 3'd6, 3'd4, 3'd2), 0,  1'b0, 1'b1, 2'd3, 5);
        // never done: timeout response
        run_req(1, pack(3'd0, 3'd6, 3'd4, 3'd7), 0,  1'b0, 1'b0, 2'd0, 13);
        // done on 2nd FEED cycle is ignored
        run_req(2, pack(3'd0, 3'd6, 3'd4, 3'd7), 1,  1'b1, 1'b0, 2'd0, 13);
        // done on the final window cycle wins over expiry
        run_req(3, pack(3'd0, 3'd6, 3'd4, 3'd7), 11, 1'b1, 1'b1, 2'd1, 13);
        // done in the middle of the window
        run_req(0, pack(3'd0, 3'd6, 3'd4, 3'd7), 6,  1'b1, 1'b1, 2'd1, 8);

        // req dropped and req_seq changed after grant
        req_seq = '0;
        req_seq[SB-1:0] = pack(3'd0, 3'd6, 3'd4, 3'd2);
        req = 4'b0001;
        push(0, 1'b1, 2'd3);
        tick();
        check("t4_gnt", {28'd0, gnt}, 32'd1);
        check("t4_s0", {29'd0, det_inp}, 32'd0);
        tick();
        req = 4'b0000;
        req_seq[SB-1:0] = pack(3'd7, 3'd7, 3'd7, 3'd7);
        check("t4_s1", {29'd0, det_inp}, 32'd6);
        tick();
        check("t4_s2", {29'd0, det_inp}, 32'd4);
        tick();
        check("t4_s3", {29'd0, det_inp}, 32'd2);
        tick();
        check("t4_resp", {31'd0, resp_valid}, 32'd1);
        wait_idle();

        // reset during FEED; ptr is 0 so requester 1 wins first
        for (int r = 0; r < NREQ; r++) req_seq[r*SB +: SB] = pack(3'd0, 3'd6, 3'd4, 3'd2);
        req = 4'b1111;
        tick();
        check("t5_gnt", {28'd0, gnt}, 32'd2);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("t5_gnt_rst",  {28'd0, gnt},     32'd0);
        check("t5_inp_rst",  {29'd0, det_inp}, 32'd7);
        check("t5_busy_rst", {31'd0, busy},    32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // all requesting after reset: order 0,1,2,3,0 with 3-cycle gaps
        exp_order[0] = 4'b0001;
        exp_order[1] = 4'b0010;
        exp_order[2] = 4'b0100;
        exp_order[3] = 4'b1000;
        exp_order[4] = 4'b0001;
        push(0, 1'b1, 2'd3);
        push(1, 1'b1, 2'd3);
        push(2, 1'b1, 2'd3);
        push(3, 1'b1, 2'd3);
        push(0, 1'b1, 2'd3);
        prev  = '0;
        zeros = 0;
        ngr   = 0;
        for (int c = 0; c < 150 && ngr < 5; c++) begin
            tick();
            if (gnt == 4'b0000) begin
                zeros++;
            end else if (prev == 4'b0000) begin
                check("t3_order", {28'd0, gnt}, {28'd0, exp_order[ngr]});
                if (ngr > 0) check("t3_gap", zeros, 32'd3);
                ngr++;
                zeros = 0;
            end
            prev = gnt;
        end
        check("t3_grants", ngr, 32'd5);
        req = 4'b0000;
        wait_idle();
        repeat (3) tick();
        check("sb_empty", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
